// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC, imem handshake, in-order response FIFO.
// Optional FETCH_MISALIGN_CHECK_EN halts on misaligned redirect targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_misaligned
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic {RUN, HALT} state_e;
  logic mis_q, mis_d;
`else
  typedef enum logic {RUN} state_e;
  logic unused_lo;
  assign unused_lo = ^redirect_pc[1:0];
`endif

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d, tgt;
  logic [CW-1:0]   out_q, out_d, disc_q, disc_d;
  logic [CW-1:0]   fcnt_q, fcnt_d, qcnt_q, qcnt_d;
  logic [AW-1:0]   fwr_q, fwr_d, frd_q, frd_d;
  logic [AW-1:0]   qwr_q, qwr_d, qrd_q, qrd_d;
  logic [31:0]     fpc_q [FIFO_DEPTH];
  logic [31:0]     fcode_q [FIFO_DEPTH];
  logic [31:0]     qpc_q [FIFO_DEPTH];
  logic [CW:0]     used;
  logic            pop, acc, keep, push;

  assign pop  = inst_valid && inst_ready;
  assign acc  = imem_req_valid && imem_req_ready;
  assign keep = imem_rsp_valid && (disc_q == '0);
  assign push = keep && !redirect_valid;

  // A head leaving this cycle frees its slot, allowing back-to-back issue.
  assign used = (CW+1)'(fcnt_q) + (CW+1)'(out_q) - (CW+1)'(pop);

  assign imem_req_valid = rst_n && (state_q == RUN) && !redirect_valid
                        && (used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (fcnt_q != '0);
  assign inst_code      = fcode_q[frd_q];
  assign inst_pc        = fpc_q[frd_q];

`ifdef FETCH_MISALIGN_CHECK_EN
  assign tgt              = redirect_pc;
  assign fetch_misaligned = mis_q;
`else
  assign tgt              = {redirect_pc[31:2], 2'b00};
  assign fetch_misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q + CW'(acc) - CW'(imem_rsp_valid);
    disc_d  = disc_q;
    fcnt_d  = fcnt_q;
    qcnt_d  = qcnt_q;
    fwr_d   = fwr_q;
    frd_d   = frd_q;
    qwr_d   = qwr_q;
    qrd_d   = qrd_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    if (imem_rsp_valid && disc_q != '0)
      disc_d = disc_q - CW'(1);
    if (redirect_valid) begin
      fcnt_d = '0;
      qcnt_d = '0;
      fwr_d  = '0;
      frd_d  = '0;
      qwr_d  = '0;
      qrd_d  = '0;
      disc_d = out_q - CW'(imem_rsp_valid);
      pc_d   = tgt;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        mis_d   = 1'b1;
        state_d = HALT;
      end else begin
        mis_d   = 1'b0;
        state_d = RUN;
      end
`endif
    end else begin
      if (acc) begin
        pc_d  = pc_q + 32'd4;
        qwr_d = qwr_q + AW'(1);
      end
      if (keep)
        qrd_d = qrd_q + AW'(1);
      qcnt_d = qcnt_q + CW'(acc) - CW'(keep);
      if (push)
        fwr_d = fwr_q + AW'(1);
      if (pop)
        frd_d = frd_q + AW'(1);
      fcnt_d = fcnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
      fcnt_q  <= '0;
      qcnt_q  <= '0;
      fwr_q   <= '0;
      frd_q   <= '0;
      qwr_q   <= '0;
      qrd_q   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      fcnt_q  <= fcnt_d;
      qcnt_q  <= qcnt_d;
      fwr_q   <= fwr_d;
      frd_q   <= frd_d;
      qwr_q   <= qwr_d;
      qrd_q   <= qrd_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fpc_q[i]   <= '0;
        fcode_q[i] <= '0;
        qpc_q[i]   <= '0;
      end
    end else begin
      if (acc)
        qpc_q[qwr_q] <= pc_q;
      if (push) begin
        fpc_q[fwr_q]   <= qpc_q[qrd_q];
        fcode_q[fwr_q] <= imem_rsp_data;
      end
    end
  end

endmodule
